// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state type and byte-enable helper for the LSU
// Contents: F3_* funct3 constants, lsu_state_t, be_mask() size/offset -> byte-enable decode.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } lsu_state_t;

    // size = funct3[1:0] (0=B, 1=H, 2=W, 3=D); off = byte offset within the doubleword.
    // Only meaningful for aligned accesses; misaligned ones never reach memory.
    function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane extraction/extension, store merge and alignment check
// Ports: addr_i (byte offset), funct3_i, old_i (doubleword from memory), wdata_i (right-aligned
//        store data) -> load_data_o (extended load), merged_o (old with lanes replaced),
//        misaligned_o.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  addr_i,
    input  logic [2:0]  funct3_i,
    input  logic [63:0] old_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] load_data_o,
    output logic [63:0] merged_o,
    output logic        misaligned_o
);

    logic [63:0] shifted_old;
    logic [63:0] shifted_wdata;
    logic [7:0]  be;

    // Little-endian: the addressed byte moves to bit 0 for loads, and bit 0 of
    // the store data moves up to the addressed byte for stores.
    assign shifted_old   = old_i >> {addr_i, 3'b000};
    assign shifted_wdata = wdata_i << {addr_i, 3'b000};
    assign be            = be_mask(funct3_i[1:0], addr_i);

    always_comb begin
        merged_o = old_i;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) begin
                merged_o[i*8 +: 8] = shifted_wdata[i*8 +: 8];
            end
        end
    end

    always_comb begin
        case (funct3_i)
            F3_B:    load_data_o = {{56{shifted_old[7]}}, shifted_old[7:0]};
            F3_H:    load_data_o = {{48{shifted_old[15]}}, shifted_old[15:0]};
            F3_W:    load_data_o = {{32{shifted_old[31]}}, shifted_old[31:0]};
            F3_BU:   load_data_o = {56'd0, shifted_old[7:0]};
            F3_HU:   load_data_o = {48'd0, shifted_old[15:0]};
            F3_WU:   load_data_o = {32'd0, shifted_old[31:0]};
            default: load_data_o = shifted_old;
        endcase
    end

    always_comb begin
        case (funct3_i[1:0])
            2'd1:    misaligned_o = addr_i[0];
            2'd2:    misaligned_o = |addr_i[1:0];
            2'd3:    misaligned_o = |addr_i;
            default: misaligned_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store initiator for the doubleword data memory
// Ports: clk, rst_n; request req_valid/req_ready/req_write/req_funct3/req_addr/req_wdata;
//        response resp_valid/resp_rdata/resp_fault; memory mem_address/mem_write_data/
//        mem_read/mem_wr/mem_read_data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_write_data,
    output logic            mem_read,
    output logic            mem_wr,
    input  logic [XLEN-1:0] mem_read_data
);

    lsu_state_t      state_q, state_d;
    logic [2:0]      off_q;
    logic [2:0]      funct3_q;
    logic            write_q;
    logic            fault_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;

    logic [2:0]      align_off;
    logic [2:0]      align_f3;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merged;
    logic            misaligned;
    logic            illegal;
    logic            fault_now;
    logic            accept;

    // One aligner serves both phases: in IDLE it sees the incoming request so the
    // fault check happens at accept; afterwards it sees the latched request.
    assign align_off = (state_q == S_IDLE) ? req_addr[2:0] : off_q;
    assign align_f3  = (state_q == S_IDLE) ? req_funct3    : funct3_q;

    lsu_lane_align u_align (
        .addr_i      (align_off),
        .funct3_i    (align_f3),
        .old_i       (mem_read_data),
        .wdata_i     (wdata_q),
        .load_data_o (load_data),
        .merged_o    (merged),
        .misaligned_o(misaligned)
    );

    assign illegal   = req_write ? req_funct3[2] : (req_funct3 == 3'b111);
    assign fault_now = illegal | misaligned;
    assign accept    = (state_q == S_IDLE) && req_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (fault_now) begin
                        state_d = S_RESP;
                    end else if (req_write && (req_funct3 == F3_D)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:    state_d = write_q ? S_WR : S_RESP;
            S_WR:    state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs; mem_wr decodes straight from state_q so an asynchronous reset drops it at once.
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_fault = (state_q == S_RESP) && fault_q;
        mem_read   = (state_q == S_RD);
        mem_wr     = (state_q == S_WR);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q       <= '0;
            funct3_q    <= '0;
            write_q     <= 1'b0;
            fault_q     <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if (accept) begin
                off_q       <= req_addr[2:0];
                funct3_q    <= req_funct3;
                write_q     <= req_write;
                fault_q     <= fault_now;
                wdata_q     <= req_wdata;
                mem_addr_q  <= {req_addr[XLEN-1:3], 3'b000};
                // Full doubleword stores go straight to WR with the raw data.
                mem_wdata_q <= req_wdata;
            end
            if (state_q == S_RD) begin
                if (write_q) begin
                    mem_wdata_q <= merged;
                end else begin
                    rdata_q <= load_data;
                end
            end
            // Stores and faults report zero data, updated only as RESP is entered.
            if ((state_q == S_WR) || (accept && fault_now)) begin
                rdata_q <= '0;
            end
        end
    end

    assign resp_rdata     = rdata_q;
    assign mem_address    = mem_addr_q;
    assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit against a small doubleword memory
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic        mem_read;
    logic        mem_wr;
    logic [63:0] mem_read_data;

    load_store_unit #(.XLEN(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_fault    (resp_fault),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mem_read      (mem_read),
        .mem_wr        (mem_wr),
        .mem_read_data (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: 8 doublewords, level-sensitive write sampled on the clock edge.
    logic [63:0] dmem [0:7];
    logic        preload;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) dmem[i] <= 64'd0;
            dmem[2] <= 64'h8877665544332211;
        end else if (mem_wr) begin
            dmem[mem_address[5:3]] <= mem_write_data;
        end
    end
    assign mem_read_data = dmem[mem_address[5:3]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [63:0] rdata;
        logic        fault;
        int          resp_cyc;
        int          n_rd;
        int          n_wr;
        logic [63:0] wdata;
        logic [63:0] addr;
    } exp_t;

    exp_t sb_q [$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    endtask

    // Monitor: tallies memory activity per transaction and checks each response.
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [63:0] wr_seen_data = '0;
    logic [63:0] addr_seen = '0;
    logic        abort_window = 1'b0;
    logic        saw_wr_abort = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (abort_window && mem_wr) saw_wr_abort = 1'b1;
        if (mem_read && mem_wr) chk("rd_wr_exclusive", 64'd1, 64'd0);
        if (!rst_n) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (mem_read) begin
                rd_cnt++;
                addr_seen = mem_address;
            end
            if (mem_wr) begin
                wr_cnt++;
                wr_seen_data = mem_write_data;
                addr_seen = mem_address;
            end
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_rdata"}, resp_rdata, e.rdata);
                    chk({e.name, "_fault"}, {63'd0, resp_fault}, {63'd0, e.fault});
                    chk({e.name, "_latency"}, 64'(cyc), 64'(e.resp_cyc));
                    chk({e.name, "_nrd"}, 64'(rd_cnt), 64'(e.n_rd));
                    chk({e.name, "_nwr"}, 64'(wr_cnt), 64'(e.n_wr));
                    if (e.n_wr != 0) chk({e.name, "_wdata"}, wr_seen_data, e.wdata);
                    if (e.n_rd + e.n_wr != 0) chk({e.name, "_addr"}, addr_seen, e.addr);
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic issue(input string name, input logic wr, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] exp_rdata, input logic exp_fault, input int lat,
                         input int n_rd, input int n_wr, input logic [63:0] exp_wdata);
        exp_t e;
        wait_ready();
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        e.name     = name;
        e.rdata    = exp_rdata;
        e.fault    = exp_fault;
        e.resp_cyc = cyc + lat;
        e.n_rd     = n_rd;
        e.n_wr     = n_wr;
        e.wdata    = exp_wdata;
        e.addr     = {addr[63:3], 3'b000};
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
        chk({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd0);
        chk({tag, "_resp_fault"}, {63'd0, resp_fault}, 64'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 64'd0);
        chk({tag, "_mem_address"}, mem_address, 64'd0);
        chk({tag, "_mem_wdata"}, mem_write_data, 64'd0);
        chk({tag, "_mem_read"}, {63'd0, mem_read}, 64'd0);
        chk({tag, "_mem_wr"}, {63'd0, mem_wr}, 64'd0);
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        preload    = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        preload = 1'b0;
        rst_n   = 1'b1;

        //     name     wr    f3      addr        wdata                   exp_rdata               flt lat rd wr exp_wdata
        issue("lb",     1'b0, 3'b000, 64'h17, 64'h0,                  64'hFFFFFFFFFFFFFF88, 1'b0, 2, 1, 0, 64'h0);
        issue("lbu",    1'b0, 3'b100, 64'h17, 64'h0,                  64'h0000000000000088, 1'b0, 2, 1, 0, 64'h0);
        issue("lw",     1'b0, 3'b010, 64'h14, 64'h0,                  64'hFFFFFFFF88776655, 1'b0, 2, 1, 0, 64'h0);
        issue("lwu",    1'b0, 3'b110, 64'h14, 64'h0,                  64'h0000000088776655, 1'b0, 2, 1, 0, 64'h0);
        issue("ld",     1'b0, 3'b011, 64'h10, 64'h0,                  64'h8877665544332211, 1'b0, 2, 1, 0, 64'h0);
        issue("sh",     1'b1, 3'b001, 64'h12, 64'h1234ABCD,           64'h0,                  1'b0, 3, 1, 1, 64'h88776655ABCD2211);
        issue("ld_sh",  1'b0, 3'b011, 64'h10, 64'h0,                  64'h88776655ABCD2211, 1'b0, 2, 1, 0, 64'h0);
        issue("sd",     1'b1, 3'b011, 64'h18, 64'hDEADBEEFCAFEF00D,   64'h0,                  1'b0, 2, 0, 1, 64'hDEADBEEFCAFEF00D);
        issue("ld_sd",  1'b0, 3'b011, 64'h18, 64'h0,                  64'hDEADBEEFCAFEF00D, 1'b0, 2, 1, 0, 64'h0);
        issue("lh_mis", 1'b0, 3'b001, 64'h13, 64'h0,                  64'h0,                  1'b1, 1, 0, 0, 64'h0);
        issue("lw_mis", 1'b0, 3'b010, 64'h12, 64'h0,                  64'h0,                  1'b1, 1, 0, 0, 64'h0);
        issue("sd_mis", 1'b1, 3'b011, 64'h14, 64'h1,                  64'h0,                  1'b1, 1, 0, 0, 64'h0);
        issue("ld_ill", 1'b0, 3'b111, 64'h10, 64'h0,                  64'h0,                  1'b1, 1, 0, 0, 64'h0);
        issue("st_ill", 1'b1, 3'b100, 64'h10, 64'h0,                  64'h0,                  1'b1, 1, 0, 0, 64'h0);
        issue("lhu",    1'b0, 3'b101, 64'h16, 64'h0,                  64'h0000000000008877, 1'b0, 2, 1, 0, 64'h0);
        issue("lh",     1'b0, 3'b001, 64'h16, 64'h0,                  64'hFFFFFFFFFFFF8877, 1'b0, 2, 1, 0, 64'h0);
        issue("sb_top", 1'b1, 3'b000, 64'h1F, 64'h55,                 64'h0,                  1'b0, 3, 1, 1, 64'h55ADBEEFCAFEF00D);
        issue("ld_sb",  1'b0, 3'b011, 64'h18, 64'h0,                  64'h55ADBEEFCAFEF00D, 1'b0, 2, 1, 0, 64'h0);

        // Drain scoreboard before the abort test.
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(sb_q.size()), 64'd0);

        // SB aborted by reset during RD: no write may ever reach memory.
        wait_ready();
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 64'h10;
        req_wdata  = 64'hAA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_in_rd", {63'd0, mem_read}, 64'd1);
        abort_window = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        abort_window = 1'b0;
        chk("abort_no_wr", {63'd0, saw_wr_abort}, 64'd0);
        chk("abort_dmem", dmem[2], 64'h88776655ABCD2211);
        chk("abort_ready", {63'd0, req_ready}, 64'd1);
        chk("abort_no_pending", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
